// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types for the cache refill arbiter: FSM states,
// grant encodings and beat-index width helpers.
package cache_refill_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        DONE_I,
        DONE_D
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam int LINE_WORDS_DEF = 4;

    function automatic int beat_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BEAT_W = beat_w(LINE_WORDS_DEF);

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Bundle of I-side, D-side, memory and stall signals around the
// refill arbiter; slave is the arbiter, master is everything else.
interface cache_refill_arbiter_if
    import cache_refill_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
);
    localparam int BW = beat_w(LINE_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_valid;
    logic [BW-1:0]     i_beat;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;
    logic [BW-1:0]     d_beat;
    logic              d_done;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_valid, i_beat, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid, d_beat, d_done,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_valid, i_beat, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid, d_beat, d_done,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/cache_refill_arbiter_burst_beat_counter.sv
// Line base latch and beat counter; produces the word address of
// the current beat and flags the final beat of the line.
module cache_refill_arbiter_burst_beat_counter
    import cache_refill_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    localparam int BW        = beat_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [BW-1:0]     beat,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int LOWB = BW + 2;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LOWB) - 1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [BW-1:0]     beat_q, beat_d;

    always_comb begin
        base_d = base_q;
        beat_d = beat_q;
        if (load) begin
            base_d = addr_in & ~LOW_MASK;
            beat_d = '0;
        end else if (adv) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    assign addr = base_q + ADDR_W'({beat_q, 2'b00});
    assign last = (beat_q == BW'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill_arbiter.sv
// Arbitrates the single memory port between I-cache refills and
// D-cache refills/writebacks, one line burst at a time.
module cache_refill_arbiter
    import cache_refill_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input logic                   CPU_CLK,
    input logic                   CPU_RST_N,
    cache_refill_arbiter_if.slave bus
);
    localparam int BW = beat_w(LINE_WORDS);

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   we_q, we_d;

    logic              pick_i;
    logic              load;
    logic              adv;
    logic              last;
    logic              gnt_i;
    logic              gnt_d;
    logic              done_i;
    logic              done_d;
    logic [BW-1:0]     beat;
    logic [ADDR_W-1:0] beat_addr;
    logic [ADDR_W-1:0] load_addr;

    cache_refill_arbiter_burst_beat_counter #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_cnt (
        .clk     (CPU_CLK),
        .rst_n   (CPU_RST_N),
        .load    (load),
        .adv     (adv),
        .addr_in (load_addr),
        .beat    (beat),
        .addr    (beat_addr),
        .last    (last)
    );

    // On a tie, the side that did not win last time gets the port.
    always_comb begin
        pick_i    = bus.i_req & (~bus.d_req | (last_grant_q == GRANT_D));
        load      = (state_q == IDLE) & (bus.i_req | bus.d_req);
        load_addr = pick_i ? bus.i_addr : bus.d_addr;
        gnt_i     = (state_q == GNT_I);
        gnt_d     = (state_q == GNT_D);
        done_i    = (state_q == DONE_I);
        done_d    = (state_q == DONE_D);
        adv       = (gnt_i | gnt_d) & bus.mem_ready;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d      = pick_i ? GNT_I : GNT_D;
                    last_grant_d = pick_i ? GRANT_I : GRANT_D;
                    we_d         = ~pick_i & bus.d_we;
                end
            end
            GNT_I:   if (adv && last) state_d = DONE_I;
            GNT_D:   if (adv && last) state_d = DONE_D;
            DONE_I:  state_d = IDLE;
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
        end
    end

    assign bus.mem_rd    = gnt_i | (gnt_d & ~we_q);
    assign bus.mem_wr    = gnt_d & we_q;
    assign bus.mem_addr  = (gnt_i | gnt_d) ? beat_addr : '0;
    assign bus.mem_wdata = (gnt_d & we_q) ? bus.d_wdata : '0;

    assign bus.i_valid = gnt_i & bus.mem_ready;
    assign bus.i_rdata = (gnt_i & bus.mem_ready) ? bus.mem_rdata : '0;
    assign bus.i_beat  = gnt_i ? beat : '0;
    assign bus.i_done  = done_i;

    assign bus.d_valid = gnt_d & bus.mem_ready;
    assign bus.d_rdata = (gnt_d & bus.mem_ready & ~we_q) ? bus.mem_rdata : '0;
    assign bus.d_beat  = gnt_d ? beat : '0;
    assign bus.d_done  = done_d;

    // Gated by reset so every output reads 0 while reset is held.
    assign bus.stall_if  = CPU_RST_N & bus.i_req & ~done_i;
    assign bus.stall_mem = CPU_RST_N & bus.d_req & ~done_d;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed vector bench for cache_refill_arbiter (LINE_WORDS=4).
module tb_cache_refill_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] wbase = '0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    cache_refill_arbiter_if #(.LINE_WORDS(4), .ADDR_W(32)) bus ();

    cache_refill_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .CPU_CLK   (clk),
        .CPU_RST_N (rst_n),
        .bus       (bus)
    );

    assign bus.d_wdata = wbase + 32'(bus.d_beat);

    typedef struct {
        logic        rs;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic        rdy;
        logic        rd;
        logic        wr;
        logic [31:0] maddr;
        logic        iv;
        logic [1:0]  ib;
        logic        idn;
        logic        dv;
        logic [1:0]  db;
        logic        ddn;
        logic        sif;
        logic        smem;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(
        logic rs, logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
        logic [31:0] daddr, logic rdy, logic rd, logic wr, logic [31:0] maddr,
        logic iv, logic [1:0] ib, logic idn, logic dv, logic [1:0] db,
        logic ddn, logic sif, logic smem);
        vec_t v;
        v.rs = rs; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq;
        v.dwe = dwe; v.daddr = daddr; v.rdy = rdy; v.rd = rd; v.wr = wr;
        v.maddr = maddr; v.iv = iv; v.ib = ib; v.idn = idn; v.dv = dv;
        v.db = db; v.ddn = ddn; v.sif = sif; v.smem = smem;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[7];
        int eb;
        logic [31:0] mrd;
        pat = '{1, 0, 0, 1, 1, 0, 1};

        // tie after reset: D first, then I, then D again
        vt[0]  = mk(1,1,32'h4000,1,0,32'h2000,1, 0,0,32'h0,    0,0,0, 0,0,0, 1,1);
        vt[1]  = mk(0,1,32'h4000,1,0,32'h2000,1, 1,0,32'h2000, 0,0,0, 1,0,0, 1,1);
        vt[2]  = mk(0,1,32'h4000,1,0,32'h2000,1, 1,0,32'h2004, 0,0,0, 1,1,0, 1,1);
        vt[3]  = mk(0,1,32'h4000,1,0,32'h2000,1, 1,0,32'h2008, 0,0,0, 1,2,0, 1,1);
        vt[4]  = mk(0,1,32'h4000,1,0,32'h2000,1, 1,0,32'h200C, 0,0,0, 1,3,0, 1,1);
        vt[5]  = mk(0,1,32'h4000,1,0,32'h2000,1, 0,0,32'h0,    0,0,0, 0,0,1, 1,0);
        vt[6]  = mk(0,1,32'h4000,0,0,32'h2000,1, 0,0,32'h0,    0,0,0, 0,0,0, 1,0);
        vt[7]  = mk(0,1,32'h4000,0,0,32'h2000,1, 1,0,32'h4000, 1,0,0, 0,0,0, 1,0);
        vt[8]  = mk(0,1,32'h4000,0,0,32'h2000,1, 1,0,32'h4004, 1,1,0, 0,0,0, 1,0);
        vt[9]  = mk(0,1,32'h4000,0,0,32'h2000,1, 1,0,32'h4008, 1,2,0, 0,0,0, 1,0);
        vt[10] = mk(0,1,32'h4000,0,0,32'h2000,1, 1,0,32'h400C, 1,3,0, 0,0,0, 1,0);
        vt[11] = mk(0,1,32'h4000,1,0,32'h2000,1, 0,0,32'h0,    0,0,1, 0,0,0, 0,1);
        vt[12] = mk(0,1,32'h4000,1,0,32'h2000,1, 0,0,32'h0,    0,0,0, 0,0,0, 1,1);
        vt[13] = mk(0,1,32'h4000,1,0,32'h2000,1, 1,0,32'h2000, 0,0,0, 1,0,0, 1,1);
        // single I miss at 0x1234
        vt[14] = mk(1,1,32'h1234,0,0,32'h0,1, 0,0,32'h0,    0,0,0, 0,0,0, 1,0);
        vt[15] = mk(0,1,32'h1234,0,0,32'h0,1, 1,0,32'h1230, 1,0,0, 0,0,0, 1,0);
        vt[16] = mk(0,1,32'h1234,0,0,32'h0,1, 1,0,32'h1234, 1,1,0, 0,0,0, 1,0);
        vt[17] = mk(0,1,32'h1234,0,0,32'h0,1, 1,0,32'h1238, 1,2,0, 0,0,0, 1,0);
        vt[18] = mk(0,1,32'h1234,0,0,32'h0,1, 1,0,32'h123C, 1,3,0, 0,0,0, 1,0);
        vt[19] = mk(0,1,32'h1234,0,0,32'h0,1, 0,0,32'h0,    0,0,1, 0,0,0, 0,0);
        vt[20] = mk(0,0,32'h1234,0,0,32'h0,1, 0,0,32'h0,    0,0,0, 0,0,0, 0,0);

        // reset state with requests already high
        bus.i_req = 1; bus.i_addr = 32'h100; bus.d_req = 1; bus.d_we = 0;
        bus.d_addr = 32'h200; bus.mem_rdata = 32'h55; bus.mem_ready = 1;
        #12;
        chk("rst mem_rd", 32'(bus.mem_rd), 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst i_valid", 32'(bus.i_valid), 0);
        chk("rst d_valid", 32'(bus.d_valid), 0);
        chk("rst stall_if", 32'(bus.stall_if), 0);
        chk("rst stall_mem", 32'(bus.stall_mem), 0);
        chk("rst i_rdata", bus.i_rdata, 0);

        for (int i = 0; i < 21; i++) begin
            if (vt[i].rs) do_reset();
            @(negedge clk);
            mrd = 32'hC0DE_0000 + 32'(i);
            bus.i_req = vt[i].ireq; bus.i_addr = vt[i].iaddr;
            bus.d_req = vt[i].dreq; bus.d_we = vt[i].dwe;
            bus.d_addr = vt[i].daddr; bus.mem_ready = vt[i].rdy;
            bus.mem_rdata = mrd;
            #1;
            chk($sformatf("row%0d mem_rd", i), 32'(bus.mem_rd), 32'(vt[i].rd));
            chk($sformatf("row%0d mem_wr", i), 32'(bus.mem_wr), 32'(vt[i].wr));
            chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vt[i].maddr);
            chk($sformatf("row%0d i_valid", i), 32'(bus.i_valid), 32'(vt[i].iv));
            chk($sformatf("row%0d i_beat", i), 32'(bus.i_beat), 32'(vt[i].ib));
            chk($sformatf("row%0d i_done", i), 32'(bus.i_done), 32'(vt[i].idn));
            chk($sformatf("row%0d d_valid", i), 32'(bus.d_valid), 32'(vt[i].dv));
            chk($sformatf("row%0d d_beat", i), 32'(bus.d_beat), 32'(vt[i].db));
            chk($sformatf("row%0d d_done", i), 32'(bus.d_done), 32'(vt[i].ddn));
            chk($sformatf("row%0d stall_if", i), 32'(bus.stall_if), 32'(vt[i].sif));
            chk($sformatf("row%0d stall_mem", i), 32'(bus.stall_mem), 32'(vt[i].smem));
            chk($sformatf("row%0d i_rdata", i), bus.i_rdata, vt[i].iv ? mrd : 32'h0);
            chk($sformatf("row%0d d_rdata", i), bus.d_rdata,
                (vt[i].dv && !vt[i].dwe) ? mrd : 32'h0);
        end

        // D writeback with d_we dropped mid-burst (latched value wins)
        do_reset();
        @(negedge clk);
        wbase = 32'hA0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h3008; bus.mem_ready = 1;
        #1;
        chk("wb idle mem_wr", 32'(bus.mem_wr), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) bus.d_we = 0;
            #1;
            chk($sformatf("wb%0d mem_wr", k), 32'(bus.mem_wr), 1);
            chk($sformatf("wb%0d mem_rd", k), 32'(bus.mem_rd), 0);
            chk($sformatf("wb%0d mem_addr", k), bus.mem_addr, 32'h3000 + 32'(4 * k));
            chk($sformatf("wb%0d mem_wdata", k), bus.mem_wdata, 32'hA0 + 32'(k));
            chk($sformatf("wb%0d d_valid", k), 32'(bus.d_valid), 1);
        end
        @(negedge clk);
        #1;
        chk("wb d_done", 32'(bus.d_done), 1);
        chk("wb done mem_wr", 32'(bus.mem_wr), 0);
        chk("wb done mem_rd", 32'(bus.mem_rd), 0);

        // D read with stretched ready pattern
        @(negedge clk);
        bus.d_we = 0; bus.d_addr = 32'h2000; bus.mem_ready = 0;
        eb = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.mem_ready = pat[k][0];
            bus.mem_rdata = 32'hBEEF_0000 + 32'(k);
            #1;
            chk($sformatf("rp%0d mem_addr", k), bus.mem_addr, 32'h2000 + 32'(4 * eb));
            chk($sformatf("rp%0d d_beat", k), 32'(bus.d_beat), 32'(eb));
            chk($sformatf("rp%0d d_valid", k), 32'(bus.d_valid), 32'(pat[k]));
            chk($sformatf("rp%0d mem_rd", k), 32'(bus.mem_rd), 1);
            if (pat[k] == 1) begin
                chk($sformatf("rp%0d d_rdata", k), bus.d_rdata, 32'hBEEF_0000 + 32'(k));
                eb++;
            end
        end
        @(negedge clk);
        bus.mem_ready = 0;
        #1;
        chk("rp d_done", 32'(bus.d_done), 1);
        chk("rp done d_valid", 32'(bus.d_valid), 0);
        bus.d_req = 0;

        // i_req held through i_done: no regrant in DONE, regrant after IDLE
        do_reset();
        @(negedge clk);
        bus.i_req = 1; bus.i_addr = 32'h5004; bus.mem_ready = 1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        #1;
        chk("hold i_done", 32'(bus.i_done), 1);
        chk("hold done mem_rd", 32'(bus.mem_rd), 0);
        chk("hold done stall_if", 32'(bus.stall_if), 0);
        @(negedge clk);
        #1;
        chk("hold idle mem_rd", 32'(bus.mem_rd), 0);
        chk("hold idle i_done", 32'(bus.i_done), 0);
        chk("hold idle stall_if", 32'(bus.stall_if), 1);
        @(negedge clk);
        #1;
        chk("hold regrant mem_rd", 32'(bus.mem_rd), 1);
        chk("hold regrant mem_addr", bus.mem_addr, 32'h5000);
        chk("hold regrant i_beat", 32'(bus.i_beat), 0);

        // reset pulled during beat 2 of an I burst
        do_reset();
        @(negedge clk);
        bus.i_req = 1; bus.i_addr = 32'h6000; bus.mem_ready = 1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("mr beat2 i_beat", 32'(bus.i_beat), 2);
        chk("mr beat2 mem_rd", 32'(bus.mem_rd), 1);
        #1;
        rst_n = 0;
        #1;
        chk("mr rst mem_rd", 32'(bus.mem_rd), 0);
        chk("mr rst i_valid", 32'(bus.i_valid), 0);
        chk("mr rst stall_if", 32'(bus.stall_if), 0);
        chk("mr rst mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        chk("mr rst i_done", 32'(bus.i_done), 0);
        rst_n = 1;
        #1;
        chk("mr idle i_done", 32'(bus.i_done), 0);
        chk("mr idle mem_rd", 32'(bus.mem_rd), 0);
        @(negedge clk);
        #1;
        chk("mr new mem_rd", 32'(bus.mem_rd), 1);
        chk("mr new i_beat", 32'(bus.i_beat), 0);
        chk("mr new mem_addr", bus.mem_addr, 32'h6000);
        chk("mr new i_valid", 32'(bus.i_valid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Schedules the single main-memory port between the instruction-cache refill path (IF stage) and the data-cache refill/writeback path (MEM stage).
- Runs burst transfers of one cache line, one beat per accepted memory word.
- Raises per-stage stall requests that the hazard logic turns into bubbleF / bubbleM for the duration of each miss.

Parameters:
- LINE_WORDS, 4, words per cache line (power of two, 2..16)
- ADDR_W, 32, byte-address width

Ports:
- CPU_CLK  in  1  core clock, rising edge
- CPU_RST_N  in  1  asynchronous reset, active-low
- i_req  in  1  I-cache line-read request; held until i_done
- i_addr  in  ADDR_W  I-cache miss byte address
- i_rdata  out  32  read beat data to I-cache
- i_valid  out  1  i_rdata valid this cycle
- i_beat  out  log2(LINE_WORDS)  index of current I beat
- i_done  out  1  one-cycle pulse, I line complete
- d_req  in  1  D-cache request; held until d_done
- d_we  in  1  1 = line writeback, 0 = line read; stable while d_req
- d_addr  in  ADDR_W  D-cache byte address
- d_wdata  in  32  writeback word for beat index d_beat (combinational from requester)
- d_rdata  out  32  read beat data to D-cache
- d_valid  out  1  d_rdata valid / d_wdata consumed this cycle
- d_beat  out  log2(LINE_WORDS)  index of current D beat
- d_done  out  1  one-cycle pulse, D transfer complete
- mem_rd  out  1  memory read command
- mem_wr  out  1  memory write command
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  beat accepted/completed this cycle
- stall_if  out  1  IF must hold (I miss outstanding)
- stall_mem  out  1  MEM must hold (D request outstanding)

Behaviour:
- Reset: state IDLE, beat counter 0, last_grant = I. All outputs 0.
- FSM states: IDLE, GNT_I, GNT_D, DONE_I, DONE_D.
- IDLE, arbitration:
  - Only i_req -> GNT_I. Only d_req -> GNT_D.
  - Both -> grant the requester not in last_grant. After reset, a tie therefore grants D first.
  - On every grant, latch the base address = requester addr with bits [log2(LINE_WORDS)+1:0] cleared. Set beat = 0 and update last_grant.
- GNT_x:
  - mem_addr = base + 4*beat.
  - mem_rd = 1 for I or D-read; mem_wr = 1 for D-write.
  - mem_wdata = d_wdata; x_beat = beat.
  - Each cycle with mem_ready: x_valid = 1, x_rdata = mem_rdata (reads), beat += 1.
  - When mem_ready on beat == LINE_WORDS-1 -> DONE_x.
  - Without mem_ready: hold all commands and address; no valid.
- DONE_x:
  - x_done = 1 for exactly one cycle; mem_rd = mem_wr = 0.
  - All requests are ignored in this cycle, so a requester still holding req cannot be re-granted.
  - Next state is IDLE.
- Transfer latency: grant in the cycle after req is seen in IDLE. Minimum line time is LINE_WORDS cycles plus 1 DONE cycle.
- Mid-transfer request changes:
  - Dropping req mid-transfer is a protocol violation; the burst still completes.
  - A change of d_we mid-transfer is ignored; the value latched at grant is used.
- Stall outputs:
  - stall_if = i_req & ~i_done.
  - stall_mem = d_req & ~d_done.
  - Both are combinational, so a waiting (ungranted) requester also stalls.
- Valid outputs: i_valid and d_valid are never both 1; i_valid and d_valid are never asserted outside GNT_x.
- Reset asserted mid-burst: immediate return to reset state. No done pulse; memory commands drop asynchronously.
- The beat counter wraps only via the state exit, never within a burst.

Decomposition:
- Shared package holds:
  - state enum: IDLE, GNT_I, GNT_D, DONE_I, DONE_D
  - GRANT_I / GRANT_D constants
  - BEAT_W = log2(LINE_WORDS)
- One natural sub-module: burst_beat_counter. It holds the base latch, beat count, address generation and last-beat flag. The FSM and arbitration stay in the top.

Test Plan:
- Single I miss, LINE_WORDS=4, i_addr=0x0000_1234, mem_ready always 1:
  - mem_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles.
  - 4 i_valid beats, then i_done one cycle later.
  - stall_if high from req until i_done.
- Simultaneous i_req and d_req (read, d_addr=0x2000) right after reset:
  - D granted first; after d_done plus the IDLE cycle, I is granted.
  - A second simultaneous pair is granted to D again, because last_grant = I.
- D writeback, d_we=1, d_addr=0x3008, d_wdata = 0xA0+d_beat:
  - mem_wr with mem_addr 0x3000..0x300C and mem_wdata 0xA0..0xA3.
  - mem_rd stays 0 throughout; d_done after the 4th beat.
- mem_ready pattern 1,0,0,1,1,0,1:
  - beat advances only on ready cycles; mem_addr is held during wait cycles.
  - d_done follows the 4th ready.
- Requester holds i_req high through i_done:
  - no regrant in the DONE cycle.
  - regrant (new burst) only if i_req is still high in the following IDLE cycle.
- CPU_RST_N pulled low during beat 2 of an I burst:
  - mem_rd, i_valid and stall_if go 0 at once; no i_done.
  - After release, the state is IDLE and a new request starts at beat 0.
